// File: rtl/pin_check_ctrl.sv
// Sequencing controller for the 8-bit Xnor comparator stage of the lock datapath.
// It latches codes, pulses the comparator enable, counts consecutive failures and times the lockout.
module pin_check_ctrl #(
    parameter logic [7:0] RESET_SV    = 8'h00,
    parameter int         MAX_FAIL    = 3,
    parameter int         LOCK_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] CODE,
    input  logic       TRY,
    input  logic       SET,
    input  logic       CLOSE,
    input  logic [7:0] XN,
    output logic [7:0] IN_Q,
    output logic [7:0] SV,
    output logic       EN_CMP,
    output logic       UNLOCK,
    output logic       FAIL,
    output logic       LOCKED,
    output logic [3:0] FAIL_CNT
);

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        OPEN,
        LOCKOUT
    } state_t;

    localparam logic [3:0]  MAX_CNT   = 4'(MAX_FAIL);
    localparam logic [15:0] LOCK_LOAD = 16'(LOCK_CYCLES - 1);

    state_t      state;
    logic [15:0] timer;

    // Status flags are registered alongside each transition so they follow the state exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            IN_Q     <= 8'h00;
            SV       <= RESET_SV;
            EN_CMP   <= 1'b0;
            UNLOCK   <= 1'b0;
            FAIL     <= 1'b0;
            LOCKED   <= 1'b0;
            FAIL_CNT <= 4'd0;
            timer    <= 16'd0;
        end else begin
            FAIL   <= 1'b0;
            EN_CMP <= 1'b0;
            case (state)
                IDLE: begin
                    if (TRY) begin
                        IN_Q   <= CODE;
                        EN_CMP <= 1'b1;
                        state  <= CHECK;
                    end
                end
                CHECK: begin
                    if (&XN) begin
                        FAIL_CNT <= 4'd0;
                        UNLOCK   <= 1'b1;
                        state    <= OPEN;
                    end else begin
                        FAIL <= 1'b1;
                        // Reaching the limit saturates the count and starts the lockout.
                        if (FAIL_CNT >= MAX_CNT - 4'd1) begin
                            FAIL_CNT <= MAX_CNT;
                            LOCKED   <= 1'b1;
                            timer    <= LOCK_LOAD;
                            state    <= LOCKOUT;
                        end else begin
                            FAIL_CNT <= FAIL_CNT + 4'd1;
                            state    <= IDLE;
                        end
                    end
                end
                OPEN: begin
                    if (SET) begin
                        SV <= CODE;
                    end
                    if (CLOSE) begin
                        UNLOCK <= 1'b0;
                        state  <= IDLE;
                    end
                end
                LOCKOUT: begin
                    if (timer == 16'd0) begin
                        LOCKED   <= 1'b0;
                        FAIL_CNT <= 4'd0;
                        state    <= IDLE;
                    end else begin
                        timer <= timer - 16'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pin_check_ctrl.sv
// Bench for pin_check_ctrl: vector table, hand-written lockout/reset sequences and random traffic,
// all compared against a cycle-level behavioural model of the lock.
module tb_pin_check_ctrl;

    localparam int MAX_FAIL    = 3;
    localparam int LOCK_CYCLES = 16;

    localparam int M_IDLE  = 0;
    localparam int M_CHECK = 1;
    localparam int M_OPEN  = 2;
    localparam int M_LOCK  = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] code = 8'h00;
    logic       try_req = 1'b0;
    logic       set_req = 1'b0;
    logic       close_req = 1'b0;
    logic [7:0] xn;
    logic [7:0] in_q;
    logic [7:0] sv;
    logic       en_cmp;
    logic       unlock;
    logic       fail;
    logic       locked;
    logic [3:0] fail_cnt;

    int tests = 0;
    int failures = 0;

    int m_mode;
    int m_in;
    int m_sv;
    int m_cnt;
    int m_fail;
    int m_left;

    typedef struct {
        logic [7:0] code;
        logic       tr;
        logic       st;
        logic       cl;
        logic       e_en;
        logic       e_unl;
        logic       e_fail;
        logic       e_lck;
        logic [3:0] e_cnt;
        logic [7:0] e_sv;
    } vec_t;

    vec_t vecs [17];

    pin_check_ctrl #(
        .RESET_SV    (8'h00),
        .MAX_FAIL    (MAX_FAIL),
        .LOCK_CYCLES (LOCK_CYCLES)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .CODE     (code),
        .TRY      (try_req),
        .SET      (set_req),
        .CLOSE    (close_req),
        .XN       (xn),
        .IN_Q     (in_q),
        .SV       (sv),
        .EN_CMP   (en_cmp),
        .UNLOCK   (unlock),
        .FAIL     (fail),
        .LOCKED   (locked),
        .FAIL_CNT (fail_cnt)
    );

    // Stand-in for the Xnor stage: bitwise equality, forced to zero when disabled.
    assign xn = en_cmp ? ~(in_q ^ sv) : 8'h00;

    always #5 clk = ~clk;

    task automatic check_val(input string name, input int actual, input int expected);
        tests++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = M_IDLE;
        m_in   = 0;
        m_sv   = 0;
        m_cnt  = 0;
        m_fail = 0;
        m_left = 0;
    endtask

    // One clock of the lock's behaviour, using the inputs presented before the edge.
    task automatic model_step(input int c, input int t, input int s, input int cl);
        m_fail = 0;
        case (m_mode)
            M_IDLE: begin
                if (t != 0) begin
                    m_in   = c;
                    m_mode = M_CHECK;
                end
            end
            M_CHECK: begin
                if (m_in == m_sv) begin
                    m_cnt  = 0;
                    m_mode = M_OPEN;
                end else begin
                    m_fail = 1;
                    m_cnt  = (m_cnt + 1 > MAX_FAIL) ? MAX_FAIL : m_cnt + 1;
                    if (m_cnt == MAX_FAIL) begin
                        m_left = LOCK_CYCLES;
                        m_mode = M_LOCK;
                    end else begin
                        m_mode = M_IDLE;
                    end
                end
            end
            M_OPEN: begin
                if (s != 0) m_sv = c;
                if (cl != 0) m_mode = M_IDLE;
            end
            default: begin
                m_left = m_left - 1;
                if (m_left == 0) begin
                    m_cnt  = 0;
                    m_mode = M_IDLE;
                end
            end
        endcase
    endtask

    task automatic checkOutput();
        check_val("IN_Q", int'(in_q), m_in);
        check_val("SV", int'(sv), m_sv);
        check_val("EN_CMP", int'(en_cmp), int'(m_mode == M_CHECK));
        check_val("UNLOCK", int'(unlock), int'(m_mode == M_OPEN));
        check_val("FAIL", int'(fail), m_fail);
        check_val("LOCKED", int'(locked), int'(m_mode == M_LOCK));
        check_val("FAIL_CNT", int'(fail_cnt), m_cnt);
    endtask

    task automatic applyStimulus(input logic [7:0] c, input logic t, input logic s, input logic cl);
        code      = c;
        try_req   = t;
        set_req   = s;
        close_req = cl;
        @(posedge clk);
        model_step(int'(c), int'(t), int'(s), int'(cl));
        #1;
        checkOutput();
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        code      = 8'h00;
        try_req   = 1'b0;
        set_req   = 1'b0;
        close_req = 1'b0;
        #2;
        model_reset();
        checkOutput();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wrong_try(input logic [7:0] c);
        applyStimulus(c, 1'b1, 1'b0, 1'b0);
        applyStimulus(8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int lock_count;
        int budget;
        model_reset();

        vecs[0]  = '{8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00};
        vecs[1]  = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 8'h00};
        vecs[2]  = '{8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 8'hA5};
        vecs[3]  = '{8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 8'hA5};
        vecs[4]  = '{8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 8'hA5};
        vecs[5]  = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 8'hA5};
        vecs[6]  = '{8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 8'hA5};
        vecs[7]  = '{8'hA4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 8'hA5};
        vecs[8]  = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1, 8'hA5};
        vecs[9]  = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 8'hA5};
        vecs[10] = '{8'hFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 8'hA5};
        vecs[11] = '{8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 8'hA5};
        vecs[12] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 8'hA5};
        vecs[13] = '{8'h3C, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 8'h3C};
        vecs[14] = '{8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 8'h3C};
        vecs[15] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 8'h3C};
        vecs[16] = '{8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 8'h3C};

        do_reset();
        check_val("reset SV", int'(sv), 8'h00);

        for (int i = 0; i < 17; i++) begin
            applyStimulus(vecs[i].code, vecs[i].tr, vecs[i].st, vecs[i].cl);
            check_val($sformatf("vec%0d EN_CMP", i), int'(en_cmp), int'(vecs[i].e_en));
            check_val($sformatf("vec%0d UNLOCK", i), int'(unlock), int'(vecs[i].e_unl));
            check_val($sformatf("vec%0d FAIL", i), int'(fail), int'(vecs[i].e_fail));
            check_val($sformatf("vec%0d LOCKED", i), int'(locked), int'(vecs[i].e_lck));
            check_val($sformatf("vec%0d FAIL_CNT", i), int'(fail_cnt), int'(vecs[i].e_cnt));
            check_val($sformatf("vec%0d SV", i), int'(sv), int'(vecs[i].e_sv));
        end

        // Three misses against the reset code, then a lockout that must ignore TRY.
        do_reset();
        wrong_try(8'h01);
        check_val("miss1 FAIL_CNT", int'(fail_cnt), 1);
        wrong_try(8'h02);
        check_val("miss2 FAIL_CNT", int'(fail_cnt), 2);
        applyStimulus(8'h03, 1'b1, 1'b0, 1'b0);
        applyStimulus(8'h00, 1'b1, 1'b0, 1'b0);
        check_val("miss3 FAIL_CNT", int'(fail_cnt), 3);
        check_val("miss3 FAIL", int'(fail), 1);
        lock_count = int'(locked);
        budget = 0;
        while (locked && budget < 40) begin
            applyStimulus(8'h00, 1'b1, 1'b0, 1'b0);
            if (locked) lock_count++;
            budget++;
        end
        check_val("lockout length", lock_count, LOCK_CYCLES);
        check_val("post-lock FAIL_CNT", int'(fail_cnt), 0);
        check_val("post-lock UNLOCK", int'(unlock), 0);
        applyStimulus(8'h00, 1'b1, 1'b0, 1'b0);
        applyStimulus(8'h00, 1'b0, 1'b0, 1'b0);
        check_val("post-lock UNLOCK after TRY", int'(unlock), 1);

        // Two misses then a hit: count clears without lockout.
        applyStimulus(8'h00, 1'b0, 1'b0, 1'b1);
        wrong_try(8'h11);
        wrong_try(8'h22);
        applyStimulus(8'h00, 1'b1, 1'b0, 1'b0);
        applyStimulus(8'h00, 1'b0, 1'b0, 1'b0);
        check_val("hit clears FAIL_CNT", int'(fail_cnt), 0);
        check_val("hit UNLOCK", int'(unlock), 1);
        check_val("hit no lockout", int'(locked), 0);
        applyStimulus(8'h5A, 1'b0, 1'b1, 1'b1);
        wrong_try(8'h33);
        check_val("fresh miss FAIL_CNT", int'(fail_cnt), 1);

        // Lock out against SV=5A, then drop reset when the timer holds 7.
        wrong_try(8'h01);
        applyStimulus(8'h02, 1'b1, 1'b0, 1'b0);
        applyStimulus(8'h00, 1'b0, 1'b0, 1'b0);
        check_val("second lockout LOCKED", int'(locked), 1);
        for (int i = 0; i < 8; i++) applyStimulus(8'h00, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #2;
        model_reset();
        check_val("async reset LOCKED", int'(locked), 0);
        check_val("async reset FAIL_CNT", int'(fail_cnt), 0);
        check_val("async reset SV", int'(sv), 8'h00);
        checkOutput();
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(8'h00, 1'b1, 1'b0, 1'b0);
        applyStimulus(8'h00, 1'b0, 1'b0, 1'b0);
        check_val("after reset UNLOCK", int'(unlock), 1);

        // Random traffic, codes biased toward the stored value so hits occur.
        for (int i = 0; i < 500; i++) begin
            logic [7:0] rc;
            rc = ($urandom_range(0, 1) == 1) ? 8'(m_sv) : 8'($urandom);
            applyStimulus(rc, 1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0),
                          ($urandom_range(0, 4) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule

// File: doc/pin_check_ctrl.md
Name: pin_check_ctrl

Overview:
Sequential controller around the 8-bit Xnor comparator stage of the lock datapath. It latches the entered code and the stored code and drives both into Xnor. It pulses Xnor's enable for one cycle, then consumes the 8-bit XNOR result to decide match or mismatch. It tracks consecutive failures and enforces a timed lockout.

Parameters:
- RESET_SV, 8'h00, stored code value after reset.
- MAX_FAIL, 3, consecutive mismatches that trigger lockout; legal range 1..15.
- LOCK_CYCLES, 16, lockout duration in clk cycles; legal range 1..65535.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- CODE  in  8  user-entered code.
- TRY  in  1  request a comparison; sampled each cycle.
- SET  in  1  request to overwrite the stored code with CODE; honoured only in OPEN.
- CLOSE  in  1  relock request; honoured only in OPEN.
- XN  in  8  result from Xnor Out.
- IN_Q  out  8  latched entered code, drives Xnor IN.
- SV  out  8  stored code, drives Xnor SV.
- EN_CMP  out  1  drives Xnor en.
- UNLOCK  out  1  high while in OPEN.
- FAIL  out  1  one-cycle pulse per mismatch.
- LOCKED  out  1  high while in LOCKOUT.
- FAIL_CNT  out  4  current consecutive-failure count.

Behaviour:
- Interface: one clock domain. Reset is asynchronous and active-low. Naming: clk, rst_n.
- Reset values:
  - state=IDLE.
  - IN_Q=8'h00, SV=RESET_SV.
  - EN_CMP=0, UNLOCK=0, FAIL=0, LOCKED=0, FAIL_CNT=0.
  - Lockout timer=0.
- All outputs are registered or decoded from state only, never from the current-cycle inputs.
- FSM states: IDLE, CHECK, OPEN, LOCKOUT.
- IDLE:
  - TRY=1 captures IN_Q<=CODE and moves to CHECK.
  - SET and CLOSE are ignored.
- CHECK (exactly one cycle):
  - EN_CMP=1 for the whole cycle.
  - XN is sampled at the end of the cycle. Match means all 8 bits of XN are 1.
  - Match: go to OPEN, FAIL_CNT<=0.
  - Mismatch: FAIL pulses high in the next cycle, and FAIL_CNT<=FAIL_CNT+1.
    - If the new count equals MAX_FAIL: go to LOCKOUT and load timer<=LOCK_CYCLES-1.
    - Otherwise: go to IDLE.
  - TRY, SET and CLOSE are ignored.
- Latency: TRY sampled at edge k, CHECK occupies cycle k..k+1, UNLOCK/FAIL/LOCKED are valid after edge k+1.
- OPEN:
  - UNLOCK=1.
  - SET=1 loads SV<=CODE.
  - CLOSE=1 moves to IDLE.
  - SET and CLOSE in the same cycle: SV is updated and the state moves to IDLE.
  - TRY is ignored.
- LOCKOUT:
  - LOCKED=1. TRY, SET and CLOSE are all ignored.
  - The timer decrements each cycle.
  - When the timer is 0: go to IDLE and clear FAIL_CNT.
  - Total cycles in LOCKOUT = LOCK_CYCLES.
- FAIL_CNT saturates at MAX_FAIL and never wraps. It clears only on a match, on lockout expiry, or on reset.
- EN_CMP is 0 in every state except CHECK. Xnor output is therefore 0 outside CHECK, and XN is ignored outside CHECK.
- Reset asserted mid-operation, including in CHECK or LOCKOUT, returns immediately to the reset values. A stored code set via SET is lost (SV returns to RESET_SV).
- A TRY held high continuously in IDLE retriggers CHECK every other cycle (IDLE→CHECK→IDLE…).

Test Plan:
- Reset, then TRY with CODE=8'h00 (matches RESET_SV) → EN_CMP high for 1 cycle, UNLOCK=1 two edges after TRY, FAIL_CNT=0.
- In OPEN: SET with CODE=8'hA5, then CLOSE. Next TRY with CODE=8'hA5 → UNLOCK. TRY with 8'hA4 → FAIL pulse of 1 cycle, FAIL_CNT=1, UNLOCK=0.
- Three wrong TRYs (8'h01, 8'h02, 8'h03) against SV=8'h00 → FAIL_CNT 1, 2, 3. LOCKED=1 for exactly 16 cycles, TRY with 8'h00 ignored during lockout. Then IDLE with FAIL_CNT=0, and TRY 8'h00 → UNLOCK.
- Two wrong TRYs then a correct TRY → FAIL_CNT returns to 0 and no lockout occurs. A further wrong TRY → FAIL_CNT=1.
- SET and CLOSE asserted in the same OPEN cycle with CODE=8'h3C → SV=8'h3C and state=IDLE. SET asserted in IDLE with 8'hFF → SV unchanged.
- rst_n dropped mid-LOCKOUT (timer=7) → LOCKED=0, FAIL_CNT=0, SV=RESET_SV asynchronously. After release, TRY 8'h00 → UNLOCK.
